// File: rtl/spi_flash_responder.sv
// SPI flash target (mode 0, single-bit) that stands in for the boot flash.
// SCK, CS_n and MOSI are oversampled in the ext_clk domain. The responder serves three
// opcodes from an internal byte array: READ (0x03), RDID (0x9F) and RDSR (0x05). The array
// is preloaded through a byte-wide load port.
//
// Ports:
//   ext_clk_i           system clock; all logic is rising-edge
//   ext_rst_ni          asynchronous active-low reset
//   spi_flash_clk_i     SCK from the initiator, idle low
//   spi_flash_cs_n_i    chip select, active low
//   spi_flash_mosi_i    initiator -> target data
//   spi_flash_miso_o    target -> initiator data
//   spi_flash_miso_oe_o 1 = drive miso (pad oeb = ~oe)
//   load_we_i           write load_data_i to array[load_addr_i]
//   load_addr_i         preload address
//   load_data_i         preload byte
//   busy_o              high while a transaction is being tracked
//   cmd_err_o           one-cycle pulse on an unsupported opcode
module spi_flash_responder #(
  parameter int unsigned AW       = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int unsigned SYNC     = 2
) (
  input  logic          ext_clk_i,
  input  logic          ext_rst_ni,
  input  logic          spi_flash_clk_i,
  input  logic          spi_flash_cs_n_i,
  input  logic          spi_flash_mosi_i,
  output logic          spi_flash_miso_o,
  output logic          spi_flash_miso_oe_o,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [7:0]    load_data_i,
  output logic          busy_o,
  output logic          cmd_err_o
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;
  typedef enum logic [1:0] {SrcRead, SrcId, SrcZero} src_e;

  // Input synchronisers
  logic [SYNC-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic            sck_prev_q, cs_prev_q;
  logic            sck_s, cs_n_s, mosi_s;
  logic            sck_rise, sck_fall, cs_fall;

  // CS_n synchroniser and history reset to "selected". A chip select that is already low
  // when reset releases therefore never looks like a fresh falling edge. The transaction
  // only starts after the initiator deasserts and reasserts CS_n.
  always_ff @(posedge ext_clk_i or negedge ext_rst_ni) begin
    if (!ext_rst_ni) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC-2:0], spi_flash_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC-2:0], spi_flash_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], spi_flash_mosi_i};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_n_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC-1];
  assign cs_n_s   = cs_sync_q[SYNC-1];
  assign mosi_s   = mosi_sync_q[SYNC-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_n_s & cs_prev_q;

  // Byte array: no reset so the preloaded contents survive ext_rst_ni
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd_data_q;
  logic [AW-1:0] addr_q, addr_d;

  // Read data is registered. An SCK fall always comes at least 4 cycles after the rise
  // that moves addr_q, so the registered read is settled before the byte is fetched.
  // On a same-cycle collision the read returns the old byte.
  always_ff @(posedge ext_clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_data_i;
    end
    rd_data_q <= mem[addr_q];
  end

  // Transfer FSM
  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [1:0]  id_idx_q, id_idx_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        cmd_err_q, cmd_err_d;

  always_ff @(posedge ext_clk_i or negedge ext_rst_ni) begin
    if (!ext_rst_ni) begin
      state_q   <= StIdle;
      src_q     <= SrcRead;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      id_idx_q  <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      id_idx_q  <= id_idx_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  logic [23:0] sh_next;
  logic [7:0]  id_byte, src_byte;

  assign sh_next = {shift_q[22:0], mosi_s};

  always_comb begin
    id_byte = JEDEC_ID[7:0];
    case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  end

  always_comb begin
    src_byte = 8'h00;
    unique case (src_q)
      SrcRead: src_byte = rd_data_q;
      SrcId:   src_byte = id_byte;
      default: src_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    id_idx_d  = id_idx_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    cmd_err_d = 1'b0;

    if (state_q != StIdle && cs_n_s) begin
      // Deselect aborts from any state; partial bytes are dropped
      state_d   = StIdle;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            shift_d   = sh_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              case (sh_next[7:0])
                8'h03: state_d = StAddr;
                8'h9F: begin
                  state_d  = StData;
                  src_d    = SrcId;
                  id_idx_d = '0;
                  oe_d     = 1'b1;
                end
                8'h05: begin
                  state_d = StData;
                  src_d   = SrcZero;
                  oe_d    = 1'b1;
                end
                default: begin
                  state_d   = StIgnore;
                  cmd_err_d = 1'b1;
                end
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            shift_d   = sh_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              addr_d    = sh_next[AW-1:0];
              src_d     = SrcRead;
              state_d   = StData;
              oe_d      = 1'b1;
            end
          end
        end
        StData: begin
          // bit_cnt_q counts rises within the current byte. A fall seen while it is 0
          // starts a new byte, so that is when the next byte is taken from its source.
          if (sck_fall) begin
            if (bit_cnt_q == 5'd0) begin
              miso_d = src_byte[7];
              tx_d   = {src_byte[6:0], 1'b0};
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end else if (sck_rise) begin
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + AW'(1);
              id_idx_d  = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        StIgnore: begin
          oe_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign spi_flash_miso_o    = miso_q;
  assign spi_flash_miso_oe_o = oe_q;
  assign busy_o              = (state_q != StIdle);
  assign cmd_err_o           = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, oe, busy, cerr;
  logic        we = 1'b0;
  logic [15:0] laddr = '0;
  logic [7:0]  ldata = '0;

  int n_checks = 0;
  int n_errs = 0;
  int err_pulses = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nbytes;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [8];

  spi_flash_responder #(
    .AW(16),
    .JEDEC_ID(24'hEF4016),
    .SYNC(2)
  ) dut (
    .ext_clk_i          (clk),
    .ext_rst_ni         (rst_n),
    .spi_flash_clk_i    (sck),
    .spi_flash_cs_n_i   (cs_n),
    .spi_flash_mosi_i   (mosi),
    .spi_flash_miso_o   (miso),
    .spi_flash_miso_oe_o(oe),
    .load_we_i          (we),
    .load_addr_i        (laddr),
    .load_data_i        (ldata),
    .busy_o             (busy),
    .cmd_err_o          (cerr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cerr === 1'b1) err_pulses <= err_pulses + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    we = 1'b1;
    laddr = a;
    ldata = d;
    wait_clks(1);
    we = 1'b0;
  endtask

  task automatic sck_bit(input logic b, output logic m, output logic o);
    mosi = b;
    wait_clks(HALF);
    sck = 1'b1;
    m = miso;
    o = oe;
    wait_clks(HALF);
    sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic oe_all);
    logic m, o;
    oe_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(tx[i], m, o);
      rx[i] = m;
      oe_all &= o;
    end
  endtask

  task automatic cs_end();
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] rx, want;
    logic       o, oe_ok;
    int         p;
    p = err_pulses;
    cs_n = 1'b0;
    wait_clks(4);
    xfer(v.op, rx, o);
    if (v.op == 8'h03) begin
      xfer(v.addr[23:16], rx, o);
      xfer(v.addr[15:8], rx, o);
      xfer(v.addr[7:0], rx, o);
    end
    for (int i = 0; i < v.nbytes; i++) exp_q.push_back(v.exp[47 - 8*i -: 8]);
    oe_ok = 1'b1;
    for (int i = 0; i < v.nbytes; i++) begin
      xfer(8'h00, rx, o);
      oe_ok &= o;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL %s byte%0d: got %0h, expected nothing queued", tag, i, rx);
      end else begin
        want = exp_q.pop_front();
        check($sformatf("%s byte%0d", tag, i), {24'h0, rx}, {24'h0, want});
      end
    end
    check({tag, " oe"}, {31'h0, oe_ok}, 32'h1);
    cs_end();
    check({tag, " no_cmd_err"}, err_pulses - p, 0);
  endtask

  initial begin
    logic [7:0] rx;
    logic       o, m, acc;
    int         p;

    vecs[0] = '{8'h03, 24'h000010, 4, 48'h1122_3344_0000};
    vecs[1] = '{8'h03, 24'h01FFFF, 2, 48'hA55A_0000_0000};
    vecs[2] = '{8'h9F, 24'h000000, 6, 48'hEF40_16EF_4016};
    vecs[3] = '{8'h05, 24'h000000, 2, 48'h0000_0000_0000};
    vecs[4] = '{8'h03, 24'h00FFFE, 3, 48'hC3A5_5A00_0000};
    vecs[5] = '{8'h03, 24'h000010, 1, 48'h1100_0000_0000};
    vecs[6] = '{8'h03, 24'h000012, 2, 48'h3344_0000_0000};
    vecs[7] = '{8'h03, 24'h000010, 4, 48'h1122_3344_0000};

    // Reset state
    wait_clks(3);
    check("rst miso", {31'h0, miso}, 32'h0);
    check("rst oe", {31'h0, oe}, 32'h0);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst cmd_err", {31'h0, cerr}, 32'h0);
    rst_n = 1'b1;
    wait_clks(3);

    preload(16'h0010, 8'h11);
    preload(16'h0011, 8'h22);
    preload(16'h0012, 8'h33);
    preload(16'h0013, 8'h44);
    preload(16'hFFFF, 8'hA5);
    preload(16'h0000, 8'h5A);
    preload(16'hFFFE, 8'hC3);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Unsupported opcode: one cmd_err pulse, miso stays undriven
    p = err_pulses;
    cs_n = 1'b0;
    wait_clks(4);
    xfer(8'hAB, rx, o);
    acc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sck_bit(1'b0, m, o);
      acc |= o;
    end
    check("ignore oe", {31'h0, acc}, 32'h0);
    check("ignore cmd_err pulses", err_pulses - p, 1);
    cs_end();
    check("ignore busy after cs", {31'h0, busy}, 32'h0);
    run_vec(vecs[5], "after_ignore");

    // CS_n raised after 13 address bits
    cs_n = 1'b0;
    wait_clks(4);
    xfer(8'h03, rx, o);
    for (int i = 0; i < 13; i++) sck_bit(1'b1, m, o);
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(3);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort oe", {31'h0, oe}, 32'h0);
    wait_clks(8);
    run_vec(vecs[6], "after_abort");

    // Reset mid-DATA
    cs_n = 1'b0;
    wait_clks(4);
    xfer(8'h03, rx, o);
    xfer(8'h00, rx, o);
    xfer(8'h00, rx, o);
    xfer(8'h10, rx, o);
    xfer(8'h00, rx, o);
    check("pre_rst byte", {24'h0, rx}, 32'h11);
    for (int i = 0; i < 3; i++) sck_bit(1'b0, m, o);
    rst_n = 1'b0;
    #1;
    check("midrst miso", {31'h0, miso}, 32'h0);
    check("midrst oe", {31'h0, oe}, 32'h0);
    check("midrst busy", {31'h0, busy}, 32'h0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    acc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sck_bit(1'b0, m, o);
      acc |= o | busy;
    end
    check("post_rst stays idle", {31'h0, acc}, 32'h0);
    cs_end();
    run_vec(vecs[7], "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
